elevator_request_scheduler: RTL and testbench

Upstream call-management stage for the four-floor elevator. Latches car/hall call buttons into a pending set and selects the next target floor with a SCAN policy (keep direction while calls remain ahead, else reverse). Drives `REQUESTED_FLOOR` into the elevator control system, one request at a time. Retires each request on `COMPLETE` at the matching floor, and holds dispatch while a door or weight alert is active.

---
 rtl/elevator_request_scheduler_if.sv | 30 +++
 rtl/elevator_request_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_request_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_request_scheduler_if
//  Brief    : Call-button / elevator-control bundle for the request scheduler.
//             master = call buttons + control/alert side, slave = scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface elevator_request_scheduler_if;
    logic [3:0] CALL_BUTTONS;
    logic [3:0] CURRENT_FLOOR;
    logic       COMPLETE;
    logic       DOOR_ALERT;
    logic       WEIGHT_ALERT;
    logic [3:0] REQUESTED_FLOOR;
    logic       REQ_VALID;
    logic [3:0] PENDING;
    logic       DIR_UP;
    logic       FAULT;

    modport master (
        output CALL_BUTTONS, CURRENT_FLOOR, COMPLETE, DOOR_ALERT, WEIGHT_ALERT,
        input  REQUESTED_FLOOR, REQ_VALID, PENDING, DIR_UP, FAULT
    );

    modport slave (
        input  CALL_BUTTONS, CURRENT_FLOOR, COMPLETE, DOOR_ALERT, WEIGHT_ALERT,
        output REQUESTED_FLOOR, REQ_VALID, PENDING, DIR_UP, FAULT
    );
endinterface
`default_nettype wire

// File: rtl/elevator_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_request_scheduler
//  Brief    : Latches four-floor call buttons and dispatches one target floor
//             at a time using a SCAN policy; retires on matching COMPLETE,
//             holds dispatch under door/weight alerts, sticky timeout fault.
//  Revision : 1.0  initial release
// ============================================================================
module elevator_request_scheduler #(
    parameter int DWELL_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    elevator_request_scheduler_if.slave io_bus
);

    localparam logic [7:0]  c_DWELL_LOAD = 8'(DWELL_CYCLES);
    localparam logic [15:0] c_TIMEOUT    = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DWELL  = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_pending;
    logic [3:0]  r_req_floor;
    logic        r_req_valid;
    logic        r_dir_up;
    logic        r_fault;
    logic [7:0]  r_dwell_cnt;
    logic [15:0] r_tmo_cnt;

    state_t      w_state_next;
    logic [3:0]  w_pend_next;
    logic [3:0]  w_clear_mask;
    logic [3:0]  w_req_floor_next;
    logic        w_req_valid_next;
    logic        w_dir_next;
    logic        w_fault_next;
    logic [7:0]  w_dwell_next;
    logic [15:0] w_tmo_next;
    logic [15:0] w_tmo_inc;

    logic        w_alert;
    logic        w_cur_onehot;
    logic [1:0]  w_cur_idx;
    logic        w_above_found;
    logic [1:0]  w_above_idx;
    logic        w_below_found;
    logic [1:0]  w_below_idx;
    logic        w_tgt_found;
    logic [1:0]  w_tgt_idx;

    assign w_alert      = io_bus.DOOR_ALERT | io_bus.WEIGHT_ALERT;
    assign w_cur_onehot = (io_bus.CURRENT_FLOOR != 4'd0) &&
                          ((io_bus.CURRENT_FLOOR & (io_bus.CURRENT_FLOOR - 4'd1)) == 4'd0);
    assign w_tmo_inc    = r_tmo_cnt + 16'd1;
    // A retirement clear always beats a simultaneous button press on the same bit.
    assign w_pend_next  = (r_pending | io_bus.CALL_BUTTONS) & ~w_clear_mask;

    // Encode the one-hot present floor into an index (only used when one-hot).
    always_comb begin
        w_cur_idx = 2'd0;
        case (io_bus.CURRENT_FLOOR)
            4'b0010: w_cur_idx = 2'd1;
            4'b0100: w_cur_idx = 2'd2;
            4'b1000: w_cur_idx = 2'd3;
            default: w_cur_idx = 2'd0;
        endcase
    end

    // Nearest pending floor strictly above and strictly below the car.
    always_comb begin
        w_above_found = 1'b0;
        w_above_idx   = 2'd0;
        w_below_found = 1'b0;
        w_below_idx   = 2'd0;
        // Descending scan: last hit is the lowest floor above the car.
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(w_cur_idx) && r_pending[i]) begin
                w_above_found = 1'b1;
                w_above_idx   = 2'(i);
            end
        end
        // Ascending scan: last hit is the highest floor below the car.
        for (int i = 0; i < 4; i++) begin
            if (i < int'(w_cur_idx) && r_pending[i]) begin
                w_below_found = 1'b1;
                w_below_idx   = 2'(i);
            end
        end
    end

    // SCAN choice: ahead first, then behind, then the car's own floor.
    always_comb begin
        w_tgt_found = 1'b1;
        w_tgt_idx   = w_cur_idx;
        if (r_dir_up && w_above_found) begin
            w_tgt_idx = w_above_idx;
        end else if (!r_dir_up && w_below_found) begin
            w_tgt_idx = w_below_idx;
        end else if (r_dir_up && w_below_found) begin
            w_tgt_idx = w_below_idx;
        end else if (!r_dir_up && w_above_found) begin
            w_tgt_idx = w_above_idx;
        end else if (r_pending[w_cur_idx]) begin
            w_tgt_idx = w_cur_idx;
        end else begin
            w_tgt_found = 1'b0;
        end
    end

    // Next-state and registered-output logic of the dispatch FSM.
    always_comb begin
        w_state_next     = r_state;
        w_clear_mask     = 4'd0;
        w_req_floor_next = r_req_floor;
        w_req_valid_next = r_req_valid;
        w_dir_next       = r_dir_up;
        w_fault_next     = r_fault;
        w_dwell_next     = r_dwell_cnt;
        w_tmo_next       = r_tmo_cnt;

        case (r_state)
            ST_IDLE: begin
                if (r_pending != 4'd0 && !w_alert && !r_fault) begin
                    w_state_next = ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (w_cur_onehot && !w_alert) begin
                    if (w_tgt_found) begin
                        w_req_floor_next = 4'b0001 << w_tgt_idx;
                        w_req_valid_next = 1'b1;
                        if (w_tgt_idx > w_cur_idx) begin
                            w_dir_next = 1'b1;
                        end else if (w_tgt_idx < w_cur_idx) begin
                            w_dir_next = 1'b0;
                        end
                        w_tmo_next   = 16'd0;
                        w_state_next = ST_WAIT;
                    end else begin
                        // Nothing left to serve; fall back rather than stall.
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_WAIT: begin
                if (io_bus.COMPLETE && io_bus.CURRENT_FLOOR == r_req_floor) begin
                    w_clear_mask     = r_req_floor;
                    w_req_valid_next = 1'b0;
                    w_req_floor_next = 4'd0;
                    w_dwell_next     = c_DWELL_LOAD;
                    w_state_next     = ST_DWELL;
                end else if (!w_alert) begin
                    // Alerts freeze the timeout; they never abort the request.
                    w_tmo_next = w_tmo_inc;
                    if (w_tmo_inc == c_TIMEOUT) begin
                        w_fault_next     = 1'b1;
                        w_req_valid_next = 1'b0;
                        w_req_floor_next = 4'd0;
                        w_state_next     = ST_IDLE;
                    end
                end
            end

            ST_DWELL: begin
                if (r_dwell_cnt <= 8'd1) begin
                    w_dwell_next = 8'd0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_dwell_next = r_dwell_cnt - 8'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every call and request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= 4'd0;
            r_req_floor <= 4'd0;
            r_req_valid <= 1'b0;
            r_dir_up    <= 1'b1;
            r_fault     <= 1'b0;
            r_dwell_cnt <= 8'd0;
            r_tmo_cnt   <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pend_next;
            r_req_floor <= w_req_floor_next;
            r_req_valid <= w_req_valid_next;
            r_dir_up    <= w_dir_next;
            r_fault     <= w_fault_next;
            r_dwell_cnt <= w_dwell_next;
            r_tmo_cnt   <= w_tmo_next;
        end
    end

    assign io_bus.REQUESTED_FLOOR = r_req_floor;
    assign io_bus.REQ_VALID       = r_req_valid;
    assign io_bus.PENDING         = r_pending;
    assign io_bus.DIR_UP          = r_dir_up;
    assign io_bus.FAULT           = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_elevator_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elevator_request_scheduler
//  Brief    : Scoreboard bench: a request-level SCAN model predicts every
//             dispatched target/direction; a monitor compares each new request.
//  Revision : 1.0  initial release
// ============================================================================
module tb_elevator_request_scheduler;

    localparam int DWELL = 8;
    localparam int TMO   = 200;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    elevator_request_scheduler_if bus();

    elevator_request_scheduler #(
        .DWELL_CYCLES   (DWELL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct packed {
        logic [3:0] tgt;
        logic       dir;
    } exp_t;

    exp_t exp_q[$];
    exp_t plan_q[$];
    int   n_checks;
    int   n_errors;
    int   m_floor;
    logic m_dir;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] req);
        check(name, {28'd0, act}, {28'd0, req});
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        check(name, {31'd0, act}, {31'd0, req});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_floor(input int f);
        m_floor = f;
        bus.CURRENT_FLOOR = 4'(1 << f);
    endtask

    // Request-level SCAN model: expand a call set into the ordered list of
    // targets the scheduler must issue, starting from the car's floor/direction.
    task automatic plan(input logic [3:0] calls);
        int       f;
        int       t;
        logic     d;
        logic [3:0] p;
        exp_t     e;
        f = m_floor;
        d = m_dir;
        p = calls;
        while (p != 4'd0) begin
            t = -1;
            if (d) begin
                for (int i = f + 1; i <= 3; i++) if (p[i] && t < 0) t = i;
                for (int i = f - 1; i >= 0; i--) if (p[i] && t < 0) t = i;
            end else begin
                for (int i = f - 1; i >= 0; i--) if (p[i] && t < 0) t = i;
                for (int i = f + 1; i <= 3; i++) if (p[i] && t < 0) t = i;
            end
            if (t < 0) t = f;
            if (t > f) d = 1'b1;
            else if (t < f) d = 1'b0;
            e.tgt = 4'(1 << t);
            e.dir = d;
            exp_q.push_back(e);
            plan_q.push_back(e);
            p[t] = 1'b0;
            f = t;
        end
        m_floor = f;
        m_dir   = d;
    endtask

    task automatic pulse_calls(input logic [3:0] calls);
        bus.CALL_BUTTONS = calls;
        tick();
        bus.CALL_BUTTONS = 4'd0;
    endtask

    task automatic wait_valid(input int budget, input string name, output int k);
        k = 0;
        while (bus.REQ_VALID !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk1(name, bus.REQ_VALID, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk4({tag, "_req_floor"}, bus.REQUESTED_FLOOR, 4'd0);
        chk1({tag, "_req_valid"}, bus.REQ_VALID, 1'b0);
        chk4({tag, "_pending"}, bus.PENDING, 4'd0);
        chk1({tag, "_dir_up"}, bus.DIR_UP, 1'b1);
        chk1({tag, "_fault"}, bus.FAULT, 1'b0);
    endtask

    // Act as the car: travel to each planned target and report completion.
    task automatic serve(input logic [3:0] start_pend, input bit rnd);
        logic [3:0] left;
        exp_t p;
        int   k;
        int   t;
        int   travel;
        bit   first;
        left  = start_pend;
        first = 1'b1;
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            t = 0;
            for (int i = 0; i < 4; i++) if (p.tgt[i]) t = i;
            wait_valid(DWELL + 40, "dispatch", k);
            if (!first) check("dwell_latency", 32'(k), 32'(DWELL + 2));
            first = 1'b0;
            if (rnd) begin
                travel = $urandom_range(0, 5);
                for (int j = 0; j < travel; j++) begin
                    bus.DOOR_ALERT = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 2) == 0) begin
                        bus.CURRENT_FLOOR = 4'(1 << ((t + int'($urandom_range(1, 3))) % 4));
                        bus.COMPLETE = 1'b1;
                    end
                    tick();
                    bus.COMPLETE = 1'b0;
                    chk1("held_valid", bus.REQ_VALID, 1'b1);
                    chk4("held_target", bus.REQUESTED_FLOOR, p.tgt);
                end
                bus.DOOR_ALERT = 1'b0;
            end
            bus.CURRENT_FLOOR = p.tgt;
            bus.COMPLETE = 1'b1;
            if (rnd && $urandom_range(0, 1) == 1) bus.CALL_BUTTONS = p.tgt;
            tick();
            bus.COMPLETE     = 1'b0;
            bus.CALL_BUTTONS = 4'd0;
            left = left & ~p.tgt;
            chk1("retire_valid", bus.REQ_VALID, 1'b0);
            chk4("retire_floor", bus.REQUESTED_FLOOR, 4'd0);
            chk4("retire_pending", bus.PENDING, left);
        end
    endtask

    task automatic settle();
        repeat (DWELL + 2) tick();
        chk1("idle_valid", bus.REQ_VALID, 1'b0);
    endtask

    // Monitor: every new request is compared against the next predicted one.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.REQ_VALID === 1'b1 && prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_request: got floor %b expected no request", bus.REQUESTED_FLOOR);
                end else begin
                    e = exp_q.pop_front();
                    chk4("req_floor", bus.REQUESTED_FLOOR, e.tgt);
                    chk1("req_dir", bus.DIR_UP, e.dir);
                end
            end
            prev = bus.REQ_VALID;
        end
    end

    // Global bound so a stuck run still terminates.
    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got no finish expected finish within bound");
        $fatal(1);
    end

    initial begin
        int         k;
        logic [3:0] calls;
        n_checks = 0;
        n_errors = 0;
        m_floor  = 0;
        m_dir    = 1'b1;
        rst = 1'b1;
        bus.CALL_BUTTONS  = 4'd0;
        bus.CURRENT_FLOOR = 4'b0001;
        bus.COMPLETE      = 1'b0;
        bus.DOOR_ALERT    = 1'b0;
        bus.WEIGHT_ALERT  = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Single call: latency of pending and request.
        set_floor(0);
        plan(4'b1000);
        pulse_calls(4'b1000);
        chk4("e0_pending", bus.PENDING, 4'b1000);
        chk1("e0_valid", bus.REQ_VALID, 1'b0);
        tick();
        chk1("e1_valid", bus.REQ_VALID, 1'b0);
        tick();
        chk1("e2_valid", bus.REQ_VALID, 1'b1);
        serve(4'b1000, 1'b0);
        settle();

        // SCAN order from floor 1 heading up.
        set_floor(1);
        plan(4'b1001);
        pulse_calls(4'b1001);
        serve(4'b1001, 1'b0);
        settle();

        // Weight alert blocks dispatch from IDLE.
        bus.WEIGHT_ALERT = 1'b1;
        plan(4'b0100);
        pulse_calls(4'b0100);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk1("alert_hold", bus.REQ_VALID, 1'b0);
        end
        bus.WEIGHT_ALERT = 1'b0;
        tick();
        chk1("release_e1", bus.REQ_VALID, 1'b0);
        tick();
        chk1("release_e2", bus.REQ_VALID, 1'b1);
        serve(4'b0100, 1'b0);
        settle();

        // Door alert in WAIT_COMPLETE freezes the timeout.
        plan(4'b0001);
        pulse_calls(4'b0001);
        wait_valid(20, "door_dispatch", k);
        bus.DOOR_ALERT = 1'b1;
        repeat (TMO + 50) tick();
        chk1("door_no_fault", bus.FAULT, 1'b0);
        chk1("door_held", bus.REQ_VALID, 1'b1);
        bus.DOOR_ALERT = 1'b0;
        serve(4'b0001, 1'b0);
        settle();

        // Wrong-floor completion ignored, then timeout fault.
        set_floor(2);
        plan(4'b0001);
        plan_q.delete();
        pulse_calls(4'b0001);
        wait_valid(20, "tmo_dispatch", k);
        bus.CURRENT_FLOOR = 4'b0010;
        bus.COMPLETE = 1'b1;
        tick();
        bus.COMPLETE = 1'b0;
        chk1("wrong_floor_valid", bus.REQ_VALID, 1'b1);
        chk4("wrong_floor_pending", bus.PENDING, 4'b0001);
        repeat (TMO - 2) tick();
        chk1("pre_tmo_fault", bus.FAULT, 1'b0);
        chk1("pre_tmo_valid", bus.REQ_VALID, 1'b1);
        tick();
        chk1("tmo_fault", bus.FAULT, 1'b1);
        chk1("tmo_valid", bus.REQ_VALID, 1'b0);
        chk4("tmo_floor", bus.REQUESTED_FLOOR, 4'd0);
        chk4("tmo_pending", bus.PENDING, 4'b0001);
        pulse_calls(4'b1000);
        chk4("fault_latch", bus.PENDING, 4'b1001);
        repeat (30) tick();
        chk1("fault_block", bus.REQ_VALID, 1'b0);
        chk1("fault_sticky", bus.FAULT, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_dir = 1'b1;
        chk1("rst_clear_fault", bus.FAULT, 1'b0);
        chk4("rst_clear_pending", bus.PENDING, 4'd0);
        tick();

        // Button held for the target during COMPLETE: clear wins.
        set_floor(0);
        plan(4'b0010);
        plan_q.delete();
        pulse_calls(4'b0010);
        wait_valid(20, "coll_dispatch", k);
        bus.CURRENT_FLOOR = 4'b0010;
        bus.COMPLETE      = 1'b1;
        bus.CALL_BUTTONS  = 4'b0010;
        tick();
        bus.COMPLETE     = 1'b0;
        bus.CALL_BUTTONS = 4'd0;
        chk4("collision_pending", bus.PENDING, 4'd0);
        chk1("collision_valid", bus.REQ_VALID, 1'b0);
        settle();

        // Reset during WAIT_COMPLETE acts immediately.
        plan(4'b0100);
        plan_q.delete();
        pulse_calls(4'b0100);
        wait_valid(20, "midrst_dispatch", k);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        tick();
        rst = 1'b0;
        m_dir = 1'b1;
        tick();

        // Randomised episodes.
        for (int ep = 0; ep < 30; ep++) begin
            set_floor(int'($urandom_range(0, 3)));
            calls = 4'($urandom_range(1, 15));
            plan(calls);
            if ($urandom_range(0, 3) == 0) begin
                bus.WEIGHT_ALERT = 1'b1;
                pulse_calls(calls);
                repeat ($urandom_range(3, 12)) begin
                    tick();
                    chk1("rnd_alert_hold", bus.REQ_VALID, 1'b0);
                end
                bus.WEIGHT_ALERT = 1'b0;
            end else begin
                pulse_calls(calls);
            end
            serve(calls, 1'b1);
            settle();
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
